// File: rtl/candgen_pkg.sv
// candgen_pkg: shared types and helpers for the radius candidate generator.
//   calc_awidth / calc_jw : derived digit and index widths
//   state_t / phase_t     : controller state and emission phase
//   cand_count            : rows in one candidate set for (J, A, free count, radius)
package candgen_pkg;

  typedef enum logic {ST_IDLE, ST_EMIT} state_t;
  typedef enum logic [1:0] {PH_BASE, PH_SINGLE, PH_PAIR} phase_t;

  function automatic int calc_awidth(input int a);
    return $clog2(a) + 1;
  endfunction

  function automatic int calc_jw(input int j);
    return $clog2(j) + 1;
  endfunction

  // 1 base row, F*(A-1) singles, C(F,2)*(A-1)^2 pairs, gated by radius.
  function automatic int cand_count(input int j, input int a, input int f, input int r);
    int ff;
    int n;
    ff = (f > j) ? j : f;
    n  = 1;
    if (r >= 1) n += ff * (a - 1);
    if (r >= 2) n += (ff * (ff - 1) / 2) * (a - 1) * (a - 1);
    return n;
  endfunction

endpackage

// File: rtl/candgen_pos_iter.sv
// candgen_pos_iter: finds the smallest free position after `from` (or at
// `from` when incl=1), where free means any position 0..J-1 except j_index.
//   from, incl, j_index : search start, inclusive flag, excluded position
//   nxt, none           : result position, and "no such position" flag
module candgen_pos_iter
  import candgen_pkg::*;
#(
  parameter int J  = 14,
  parameter int JW = 5
) (
  input  logic [JW-1:0] from,
  input  logic          incl,
  input  logic [JW-1:0] j_index,
  output logic [JW-1:0] nxt,
  output logic          none
);

  // Descending scan so the lowest qualifying position wins.
  always_comb begin
    nxt  = '0;
    none = 1'b1;
    for (int i = J - 1; i >= 0; i--) begin
      if (((incl && JW'(i) == from) || JW'(i) > from) && JW'(i) != j_index) begin
        nxt  = JW'(i);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/candidategen_radius.sv
// candidategen_radius: streams all candidates within Hamming radius 0/1/2 of
// a forced base vector (base register with one position pinned), never
// touching the pinned position. AXI-stream style output with backpressure.
//   clk, rst                          : clock, synchronous active-high reset
//   x_initial, x_initial_tvalid       : base vector load (IDLE only)
//   start_gen, J_index, A_value,      : start request, pinned position/value,
//   radius                            : radius 0, 1, 2/3
//   candidate_row, _tvalid, _tready,  : output stream
//   _tlast
//   busy, cfg_err                     : set in progress, rejected-start pulse
module candidategen_radius
  import candgen_pkg::*;
#(
  parameter  int J      = 14,
  parameter  int A      = 2,
  localparam int AWIDTH = calc_awidth(A),
  localparam int JW     = calc_jw(J)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [J*AWIDTH-1:0]   x_initial,
  input  logic                  x_initial_tvalid,
  input  logic                  start_gen,
  input  logic [JW-1:0]         J_index,
  input  logic [AWIDTH-1:0]     A_value,
  input  logic [1:0]            radius,
  output logic [J*AWIDTH-1:0]   candidate_row,
  output logic                  candidate_row_tvalid,
  input  logic                  candidate_row_tready,
  output logic                  candidate_row_tlast,
  output logic                  busy,
  output logic                  cfg_err
);

  typedef logic [J-1:0][AWIDTH-1:0] vec_t;
  typedef struct packed {
    phase_t            ph;
    logic [JW-1:0]     p;
    logic [JW-1:0]     q;
    logic [AWIDTH-1:0] k1;
    logic [AWIDTH-1:0] k2;
  } iter_t;

  localparam logic [AWIDTH-1:0] KMAX = AWIDTH'(A - 1);
  localparam logic [AWIDTH:0]   AMOD = (AWIDTH + 1)'(A);
  localparam logic [JW-1:0]     JLIM = JW'(J);

  state_t        state;
  vec_t          base_q, bvec, forced, row_n;
  iter_t         it, it_n;
  logic [JW-1:0] jidx_q, f0_q, f1_q, flast;
  int            ntot, cnt;

  logic          fixed_in, cfg_bad, adv, wrap, qend;
  logic [JW-1:0] iter_j, a_from, b_from, a_nxt, b_nxt;
  logic          a_incl, a_none, b_none;

  function automatic logic [AWIDTH-1:0] addmod(input logic [AWIDTH-1:0] d,
                                               input logic [AWIDTH-1:0] k);
    logic [AWIDTH:0] s;
    s = {1'b0, d} + {1'b0, k};
    if (s >= AMOD) s = s - AMOD;
    return s[AWIDTH-1:0];
  endfunction

  assign fixed_in = J_index < JLIM;
  assign cfg_bad  = fixed_in && (A_value >= AWIDTH'(A));
  assign adv      = candidate_row_tvalid && candidate_row_tready;
  assign wrap     = (it.k1 == KMAX) && (it.k2 == KMAX);
  // Highest free position is closed-form, so q's end is known without an iterator.
  assign flast    = (jidx_q == JW'(J - 1)) ? JW'(J - 2) : JW'(J - 1);
  assign qend     = it.q == flast;

  // In IDLE the iterators find the first two free positions for the pending
  // start; in EMIT a = next(p), b = next(q) or next(next(p)) when q wraps.
  assign iter_j = (state == ST_IDLE) ? J_index : jidx_q;
  assign a_from = (state == ST_IDLE) ? '0 : it.p;
  assign a_incl = (state == ST_IDLE);
  assign b_from = (state == ST_IDLE || qend) ? a_nxt : it.q;

  candgen_pos_iter #(.J(J), .JW(JW)) u_iter_p (
    .from(a_from), .incl(a_incl), .j_index(iter_j), .nxt(a_nxt), .none(a_none)
  );

  candgen_pos_iter #(.J(J), .JW(JW)) u_iter_q (
    .from(b_from), .incl(1'b0), .j_index(iter_j), .nxt(b_nxt), .none(b_none)
  );

  always_comb begin
    forced = base_q;
    for (int i = 0; i < J; i++)
      if (fixed_in && JW'(i) == J_index) forced[i] = A_value;
  end

  // Successor of the current iterator; running past the final row never
  // matters because the row counter ends the set.
  always_comb begin
    it_n = it;
    case (it.ph)
      PH_BASE: begin
        it_n.ph = PH_SINGLE;
        it_n.p  = f0_q;
        it_n.k1 = AWIDTH'(1);
      end
      PH_SINGLE: begin
        if (it.k1 != KMAX) begin
          it_n.k1 = it.k1 + 1'b1;
        end else if (!a_none) begin
          it_n.p  = a_nxt;
          it_n.k1 = AWIDTH'(1);
        end else begin
          it_n.ph = PH_PAIR;
          it_n.p  = f0_q;
          it_n.q  = f1_q;
          it_n.k1 = AWIDTH'(1);
          it_n.k2 = AWIDTH'(1);
        end
      end
      default: begin
        if (it.k2 != KMAX) begin
          it_n.k2 = it.k2 + 1'b1;
        end else begin
          it_n.k2 = AWIDTH'(1);
          if (it.k1 != KMAX) begin
            it_n.k1 = it.k1 + 1'b1;
          end else begin
            it_n.k1 = AWIDTH'(1);
            it_n.q  = b_nxt;
            if (qend) it_n.p = a_nxt;
          end
        end
      end
    endcase
  end

  always_comb begin
    row_n = bvec;
    for (int i = 0; i < J; i++) begin
      if (it_n.ph != PH_BASE && JW'(i) == it_n.p) row_n[i] = addmod(bvec[i], it_n.k1);
      if (it_n.ph == PH_PAIR && JW'(i) == it_n.q) row_n[i] = addmod(bvec[i], it_n.k2);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= ST_IDLE;
      base_q               <= '0;
      bvec                 <= '0;
      it                   <= '0;
      jidx_q               <= '0;
      f0_q                 <= '0;
      f1_q                 <= '0;
      ntot                 <= 0;
      cnt                  <= 0;
      candidate_row        <= '0;
      candidate_row_tvalid <= 1'b0;
      candidate_row_tlast  <= 1'b0;
      busy                 <= 1'b0;
      cfg_err              <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (x_initial_tvalid) base_q <= x_initial;
          if (start_gen) begin
            if (cfg_bad) begin
              cfg_err <= 1'b1;
            end else begin
              state                <= ST_EMIT;
              bvec                 <= forced;
              jidx_q               <= J_index;
              f0_q                 <= a_nxt;
              f1_q                 <= b_nxt;
              it                   <= '0;
              ntot                 <= cand_count(J, A, fixed_in ? J - 1 : J, int'(radius));
              cnt                  <= 1;
              candidate_row        <= forced;
              candidate_row_tvalid <= 1'b1;
              candidate_row_tlast  <= (radius == 2'd0);
              busy                 <= 1'b1;
            end
          end
        end
        ST_EMIT: begin
          if (adv) begin
            if (candidate_row_tlast) begin
              state                <= ST_IDLE;
              candidate_row_tvalid <= 1'b0;
              candidate_row_tlast  <= 1'b0;
              busy                 <= 1'b0;
            end else begin
              it                  <= it_n;
              candidate_row       <= row_n;
              cnt                 <= cnt + 1;
              candidate_row_tlast <= (cnt + 1 == ntot);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A pair row that wraps q must always have a further p and q available.
  ap_pair_adv: assert property (@(posedge clk) disable iff (rst)
    (state == ST_EMIT && adv && !candidate_row_tlast && it.ph == PH_PAIR && wrap && qend)
      |-> (!a_none && !b_none));

  ap_cnt: assert property (@(posedge clk) disable iff (rst)
    (state == ST_EMIT) |-> (cnt >= 1 && cnt <= ntot));

endmodule
